// File: rtl/pwm_pkg.sv
// Shared widths, constants and the PWM compare rule for the pwm_generator slice.
// Build option: PWM_SHADOW_EN (see pwm_generator.sv).
package pwm_pkg;

    localparam int unsigned PWM_BITS   = 8;
    localparam int unsigned PWM_PERIOD = 256;
    localparam int unsigned NUM_PINS   = 16;
    localparam logic [PWM_BITS-1:0] DUTY_FULL = 8'hFF;

    // Full-scale code forces a solid high so there is no one-step dip at the wrap.
    function automatic logic pwm_level(input logic [PWM_BITS-1:0] cnt,
                                       input logic [PWM_BITS-1:0] duty);
        return (duty == DUTY_FULL) || (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Divides clk by CLK_DIV, producing a one-cycle tick every CLK_DIV clocks.
module pwm_prescaler #(
    parameter int unsigned CLK_DIV = 13
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] pre_cnt;

    // tick is decoded from the counter register, so it is glitch-free within clk.
    assign tick = (pre_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= CNT_W'(pre_cnt + 1'b1);
        end
    end

endmodule

// File: rtl/pwm_generator.sv
// 16-pin output driver: each pin off, on, or following a shared 8-bit PWM waveform.
// Build option: define PWM_SHADOW_EN for period-aligned duty updates via a shadow register.
module pwm_generator
    import pwm_pkg::*;
#(
    parameter int unsigned CLK_DIV = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out
);

    localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'(PWM_PERIOD - 1);

    logic                tick;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty_eff;
    logic                pwm_raw;
    logic [NUM_PINS-1:0] en_out;
    logic [NUM_PINS-1:0] en_pwm;
    logic [NUM_PINS-1:0] out_nxt;

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    pwm_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Free-running period counter, wraps naturally at 2^PWM_BITS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= PWM_BITS'(pwm_cnt + 1'b1);
        end
    end

`ifdef PWM_SHADOW_EN
    logic [PWM_BITS-1:0] duty_sh;

    // Capture on the last step of a period so the new duty starts exactly at count 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_sh <= '0;
        end else if (tick && (pwm_cnt == CNT_LAST)) begin
            duty_sh <= pwm_duty_cycle;
        end
    end

    assign duty_eff = duty_sh;
`else
    logic unused_cnt_last;
    assign unused_cnt_last = ^CNT_LAST;
    assign duty_eff        = pwm_duty_cycle;
`endif

    // Pin mux: disabled pins are low regardless of PWM mode.
    always_comb begin
        pwm_raw = pwm_level(pwm_cnt, duty_eff);
        out_nxt = '0;
        for (int i = 0; i < int'(NUM_PINS); i++) begin
            if (en_out[i]) begin
                out_nxt[i] = en_pwm[i] ? pwm_raw : 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= out_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_generator.sv
// Scoreboard bench for pwm_generator: a time-based reference model predicts every output cycle
// for a CLK_DIV=4 instance and a CLK_DIV=1 instance sharing the same randomized stimulus.
module tb_pwm_generator;

    localparam int DIV_A = 4;
    localparam int DIV_B = 1;
    localparam int PER_A = 256 * DIV_A;
    localparam int PER_B = 256 * DIV_B;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty;
    logic [15:0] out_a;
    logic [15:0] out_b;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] q_a[$];
    logic [15:0] q_b[$];

    always #5 clk = ~clk;

    pwm_generator #(.CLK_DIV(DIV_A)) u_dut_a (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_out[7:0]),
        .en_reg_out_15_8 (en_out[15:8]),
        .en_reg_pwm_7_0  (en_pwm[7:0]),
        .en_reg_pwm_15_8 (en_pwm[15:8]),
        .pwm_duty_cycle  (duty),
        .out             (out_a)
    );

    pwm_generator #(.CLK_DIV(DIV_B)) u_dut_b (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_out[7:0]),
        .en_reg_out_15_8 (en_out[15:8]),
        .en_reg_pwm_7_0  (en_pwm[7:0]),
        .en_reg_pwm_15_8 (en_pwm[15:8]),
        .pwm_duty_cycle  (duty),
        .out             (out_b)
    );

    // Pin rule from the description: off / on / waveform, waveform high while count < duty.
    function automatic logic [15:0] ref_out(input int cnt, input int d,
                                            input logic [15:0] eo, input logic [15:0] ep);
        logic [15:0] r;
        logic        wave;
        wave = (d == 255) ? 1'b1 : (cnt < d);
        r = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            if (!eo[i])      r[i] = 1'b0;
            else if (!ep[i]) r[i] = 1'b1;
            else             r[i] = wave;
        end
        return r;
    endfunction

    // Model A: cycle index since reset release determines position in the period.
    int k_a = 0;
    int sh_a = 0;
    always @(posedge clk) begin
        int d;
        if (!rst_n) begin
            k_a = 0;
            sh_a = 0;
            q_a.push_back(16'h0000);
        end else begin
`ifdef PWM_SHADOW_EN
            d = sh_a;
`else
            d = int'(duty);
`endif
            q_a.push_back(ref_out((k_a / DIV_A) % 256, d, en_out, en_pwm));
            if (k_a % PER_A == PER_A - 1) sh_a = int'(duty);
            k_a++;
        end
    end

    int k_b = 0;
    int sh_b = 0;
    always @(posedge clk) begin
        int d;
        if (!rst_n) begin
            k_b = 0;
            sh_b = 0;
            q_b.push_back(16'h0000);
        end else begin
`ifdef PWM_SHADOW_EN
            d = sh_b;
`else
            d = int'(duty);
`endif
            q_b.push_back(ref_out((k_b / DIV_B) % 256, d, en_out, en_pwm));
            if (k_b % PER_B == PER_B - 1) sh_b = int'(duty);
            k_b++;
        end
    end

    // Monitor: outputs are presented every clock; compare at the opposite edge.
    always @(negedge clk) begin
        logic [15:0] e;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            n_cmp++;
            if (out_a !== e) begin
                n_fail++;
                $display("FAIL out_div4 t=%0t k=%0d got=%h exp=%h", $time, k_a, out_a, e);
            end
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            n_cmp++;
            if (out_b !== e) begin
                n_fail++;
                $display("FAIL out_div1 t=%0t k=%0d got=%h exp=%h", $time, k_b, out_b, e);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cfg(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        @(negedge clk);
        en_out = eo;
        en_pwm = ep;
        duty   = d;
    endtask

    // Asynchronous reset mid-cycle: outputs must clear without any clock edge.
    task automatic async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_a !== 16'h0000 || out_b !== 16'h0000) begin
            n_fail++;
            $display("FAIL async_reset got_a=%h got_b=%h exp=0000", out_a, out_b);
        end
        cycles(3);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        en_out = 16'h0000;
        en_pwm = 16'h0000;
        duty   = 8'h00;
        cycles(4);
        rst_n = 1'b1;

        set_cfg(16'hFFFF, 16'h0000, 8'h00);
        cycles(20);

        set_cfg(16'h00FF, 16'hFFFF, 8'h80);
        cycles(2 * PER_A);

        set_cfg(16'hFFFF, 16'hFFFF, 8'h80);
        cycles(2 * PER_A);

        set_cfg(16'hFFFF, 16'hFFFF, 8'h00);
        cycles(PER_A + PER_A / 2);
        set_cfg(16'hFFFF, 16'hFFFF, 8'hFF);
        cycles(2 * PER_A + 10);

        // Duty change 0x40 -> 0xC0 around count 100 of a period.
        async_reset();
        duty   = 8'h40;
        en_out = 16'hFFFF;
        en_pwm = 16'hFFFF;
        cycles(PER_A + 100 * DIV_A);
        duty = 8'hC0;
        cycles(2 * PER_A);

        // One-count duty: single-step pulse each period on both instances.
        set_cfg(16'hFFFF, 16'hFFFF, 8'h01);
        cycles(2 * PER_A + 50);

        for (int s = 0; s < 30; s++) begin
            logic [7:0] d;
            case ($urandom_range(0, 3))
                0:       d = 8'h00;
                1:       d = 8'hFF;
                default: d = 8'($urandom_range(0, 255));
            endcase
            set_cfg(16'($urandom), 16'($urandom), d);
            cycles($urandom_range(1, 700));
            if (s == 15) async_reset();
        end

        cycles(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
